// File: rtl/ahb_slave_resp_mux_if.sv
// Bus bundle between the AHB address decoder/slaves and the response mux.
// ds_state exposes the default-slave FSM state for observation.
interface ahb_slave_resp_mux_if #(
    parameter int SLAVE_NUM  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int PAY_LOAD   = DATA_WIDTH + 2
);
    // Handshake: hready == 1 closes the current data phase and accepts the
    // address phase (hsel_addr/htrans) presented in the same cycle; while
    // hready == 0 the master must hold its address-phase signals.
    logic [SLAVE_NUM-1:0]               hsel_addr;
    logic [1:0]                         htrans;
    logic [SLAVE_NUM-1:0][PAY_LOAD-1:0] slv_payload_in;
    logic [DATA_WIDTH-1:0]              hrdata;
    logic                               hready;
    logic                               hresp;
    logic [SLAVE_NUM-1:0]               data_sel;
    logic [1:0]                         ds_state;

    modport slave (
        input  hsel_addr,
        input  htrans,
        input  slv_payload_in,
        output hrdata,
        output hready,
        output hresp,
        output data_sel,
        output ds_state
    );

    modport master (
        output hsel_addr,
        output htrans,
        output slv_payload_in,
        input  hrdata,
        input  hready,
        input  hresp,
        input  data_sel,
        input  ds_state
    );
endinterface

// File: rtl/ahb_slave_resp_mux.sv
// AHB slave-to-master response mux with registered data-phase select and a
// built-in default slave answering unmapped active transfers with ERROR.
module ahb_slave_resp_mux #(
    parameter int SLAVE_NUM  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int PAY_LOAD   = DATA_WIDTH + 2
) (
    input  logic                  hreset_n,
    input  logic                  hclk,
    ahb_slave_resp_mux_if.slave   bus
);
    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;
    localparam logic [SLAVE_NUM-1:0] W_ONE = SLAVE_NUM'(1);

    logic [1:0]            r_ds_state;
    logic [1:0]            w_ds_next;
    logic [SLAVE_NUM-1:0]  r_data_sel;
    logic                  w_onehot;
    logic                  w_unmapped;
    logic                  w_active;
    logic                  w_unused_htrans0;
    logic                  w_hready;
    logic                  w_hresp;
    logic [DATA_WIDTH-1:0] w_hrdata;

    // Address-phase decode; only registered state reaches the outputs.
    always_comb begin
        w_onehot   = (bus.hsel_addr != '0) &&
                     ((bus.hsel_addr & (bus.hsel_addr - W_ONE)) == '0);
        w_unmapped = ~w_onehot;
        w_active   = bus.htrans[1];
    end

    assign w_unused_htrans0 = bus.htrans[0];

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_data_sel <= '0;
        end else if (w_hready) begin
            r_data_sel <= w_onehot ? bus.hsel_addr : '0;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_ds_state <= DS_IDLE;
        end else begin
            r_ds_state <= w_ds_next;
        end
    end

    // ERR2 re-applies the IDLE entry rule so back-to-back errors need no gap.
    always_comb begin
        w_ds_next = DS_IDLE;
        case (r_ds_state)
            DS_IDLE, DS_ERR2: begin
                if (w_hready && w_active && w_unmapped) begin
                    w_ds_next = DS_ERR1;
                end else begin
                    w_ds_next = DS_IDLE;
                end
            end
            DS_ERR1: w_ds_next = DS_ERR2;
            default: w_ds_next = DS_IDLE;
        endcase
    end

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        w_hrdata = '0;
        case (r_ds_state)
            DS_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = 1'b1;
            end
            DS_ERR2: begin
                w_hready = 1'b1;
                w_hresp  = 1'b1;
            end
            default: begin
                for (int i = 0; i < SLAVE_NUM; i++) begin
                    if (r_data_sel[i]) begin
                        {w_hrdata, w_hready, w_hresp} = bus.slv_payload_in[i];
                    end
                end
            end
        endcase
    end

    assign bus.hrdata   = w_hrdata;
    assign bus.hready   = w_hready;
    assign bus.hresp    = w_hresp;
    assign bus.data_sel = r_data_sel;
    assign bus.ds_state = r_ds_state;
endmodule
